// File: rtl/poseidon2_stream_adapter.sv
// Streaming front-end for the Poseidon2 hash core.
// Collects field elements over a valid/ready stream and packs them into a flat operand vector.
// Issues a one-cycle start pulse to the core, waits for done (bounded by a timeout),
// then returns the digest with error flags over a valid/ready result channel.
module poseidon2_stream_adapter #(
   parameter int DATA_W      = 256,
   parameter int MAX_ELEMS   = 15,
   parameter int SIZE_W      = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_in_valid,
   output logic                          o_in_ready,
   input  logic [DATA_W-1:0]             i_in_data,
   input  logic                          i_in_last,
   output logic                          o_core_start,
   output logic [SIZE_W-1:0]             o_core_size,
   output logic [MAX_ELEMS*DATA_W-1:0]   o_core_data,
   input  logic [DATA_W-1:0]             i_core_hash,
   input  logic                          i_core_done,
   output logic                          o_out_valid,
   input  logic                          i_out_ready,
   output logic [DATA_W-1:0]             o_out_hash,
   output logic [SIZE_W-1:0]             o_out_count,
   output logic [1:0]                    o_out_err,
   output logic                          o_busy
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RESULT  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_in_ready;
   logic [SIZE_W-1:0]   r_count;
   logic                r_ovf;
   logic [TMO_W-1:0]    r_tmo;
   logic [DATA_W-1:0]   r_out_hash;
   logic [1:0]          r_out_err;

   logic w_in_fire;
   logic w_out_fire;
   logic w_done;
   logic w_tmo_hit;
   logic w_ovf_now;
   logic w_ovf_any;
   logic w_frame_end;

   // Handshake and event decode; core_done only counts while waiting on the core
   assign w_in_fire   = r_in_ready & i_in_valid;
   assign w_out_fire  = (r_state == ST_RESULT) & i_out_ready;
   assign w_done      = (r_state == ST_WAIT) & i_core_done;
   assign w_tmo_hit   = (r_state == ST_WAIT) & ~i_core_done & (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
   assign w_ovf_now   = w_in_fire & (r_count == SIZE_W'(MAX_ELEMS));
   assign w_ovf_any   = r_ovf | w_ovf_now;
   assign w_frame_end = w_in_fire & i_in_last;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_COLLECT;
      else        r_state <= w_state_next;
   end

   // Next-state logic; an overflowed frame skips the core entirely
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_COLLECT: if (w_frame_end) w_state_next = w_ovf_any ? ST_RESULT : ST_ISSUE;
         ST_ISSUE:   w_state_next = ST_WAIT;
         ST_WAIT:    if (w_done || w_tmo_hit) w_state_next = ST_RESULT;
         ST_RESULT:  if (i_out_ready) w_state_next = ST_COLLECT;
         default:    w_state_next = ST_COLLECT;
      endcase
   end

   // Moore outputs decoded from the state register so they drop with reset
   always_comb begin
      o_core_start = (r_state == ST_ISSUE);
      o_out_valid  = (r_state == ST_RESULT);
      o_busy       = (r_state != ST_COLLECT);
   end

   // Registered in_ready follows the state we are about to enter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_in_ready <= 1'b0;
      else        r_in_ready <= (w_state_next == ST_COLLECT);
   end

   // Element count and sticky overflow; beats past the last slot are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (w_out_fire) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_in_fire && (r_count < SIZE_W'(MAX_ELEMS))) r_count <= r_count + SIZE_W'(1);
         if (w_ovf_now) r_ovf <= 1'b1;
      end
   end

   // Timeout counter runs only while waiting for the core
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  r_tmo <= '0;
      else if (w_out_fire)         r_tmo <= '0;
      else if (r_state == ST_WAIT) r_tmo <= r_tmo + TMO_W'(1);
   end

   // Result registers: digest on done, zero digest with an error code otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_hash <= '0;
         r_out_err  <= 2'b00;
      end else if (w_out_fire) begin
         r_out_hash <= '0;
         r_out_err  <= 2'b00;
      end else if (w_done) begin
         r_out_hash <= i_core_hash;
         r_out_err  <= 2'b00;
      end else if (w_tmo_hit) begin
         r_out_hash <= '0;
         r_out_err  <= 2'b10;
      end else if ((r_state == ST_COLLECT) && w_frame_end && w_ovf_any) begin
         r_out_hash <= '0;
         r_out_err  <= 2'b01;
      end
   end

   // One register per slot; slots are cleared on result handoff so unused ones read 0
   for (genvar gi = 0; gi < MAX_ELEMS; gi++) begin : g_slot
      logic [DATA_W-1:0] r_slot;

      // Capture the beat addressed to this slot
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                                    r_slot <= '0;
         else if (w_out_fire)                           r_slot <= '0;
         else if (w_in_fire && (r_count == SIZE_W'(gi))) r_slot <= i_in_data;
      end

      assign o_core_data[gi*DATA_W +: DATA_W] = r_slot;
   end

   assign o_in_ready  = r_in_ready;
   assign o_core_size = r_count;
   assign o_out_count = r_count;
   assign o_out_hash  = r_out_hash;
   assign o_out_err   = r_out_err;

endmodule

// File: tb/tb_poseidon2_stream_adapter.sv
// Directed bench for poseidon2_stream_adapter: frame packing, overflow, timeout,
// result backpressure, back-to-back frames and reset while waiting on the core.
module tb_poseidon2_stream_adapter;

   localparam int DW  = 32;
   localparam int ME  = 15;
   localparam int SW  = 4;
   localparam int TO  = 16;
   localparam int CDW = ME * DW;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [DW-1:0]  in_data;
   logic           in_last;
   logic           core_start;
   logic [SW-1:0]  core_size;
   logic [CDW-1:0] core_data;
   logic [DW-1:0]  core_hash;
   logic           core_done;
   logic           out_valid;
   logic           out_ready;
   logic [DW-1:0]  out_hash;
   logic [SW-1:0]  out_count;
   logic [1:0]     out_err;
   logic           busy;

   int n_assert = 0;
   int n_fail   = 0;
   int n_starts = 0;

   poseidon2_stream_adapter #(
      .DATA_W(DW), .MAX_ELEMS(ME), .SIZE_W(SW), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data), .i_in_last(in_last),
      .o_core_start(core_start), .o_core_size(core_size), .o_core_data(core_data),
      .i_core_hash(core_hash), .i_core_done(core_done),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_hash(out_hash),
      .o_out_count(out_count), .o_out_err(out_err), .o_busy(busy)
   );

   always #5 clk = ~clk;

   // Count start pulses seen by the core
   always @(posedge clk) if (core_start) n_starts++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [CDW-1:0] obs, input logic [CDW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CDW-1:0] exp_data(input int n, input logic [DW-1:0] base);
      logic [CDW-1:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[i*DW +: DW] = base + DW'(i);
      return v;
   endfunction

   task automatic send_beat(input logic [DW-1:0] d, input logic last, input bit rnd);
      bit fired;
      if (rnd) repeat ($urandom_range(0, 2)) tick();
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      fired    = 1'b0;
      for (int i = 0; i < 50 && !fired; i++) begin
         fired = in_ready;
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!fired) chk("beat_accept_timeout", CDW'(fired), CDW'(1));
      $display("beat data=%0h last=%0b", d, last);
   endtask

   task automatic wait_start(input string tag);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (core_start) found = 1'b1;
         else tick();
      end
      chk(tag, CDW'(found), CDW'(1));
   endtask

   task automatic receive(input logic [DW-1:0] eh, input int ec, input logic [1:0] ee, input bit rnd);
      bit got;
      bit rdy;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         out_ready = rdy;
         if (out_valid && rdy) begin
            chk("res_hash", CDW'(out_hash), CDW'(eh));
            chk("res_count", CDW'(out_count), CDW'(ec));
            chk("res_err", CDW'(out_err), CDW'(ee));
            got = 1'b1;
         end
         tick();
      end
      out_ready = 1'b0;
      if (!got) chk("result_timeout", CDW'(got), CDW'(1));
      chk("post_xfer_valid", CDW'(out_valid), CDW'(0));
      chk("post_xfer_in_ready", CDW'(in_ready), CDW'(1));
      $display("result hash=%0h count=%0d err=%0b", out_hash, out_count, out_err);
   endtask

   task automatic run_frame(input int n, input logic [DW-1:0] base, input logic [DW-1:0] h,
                            input int dly, input bit rnd);
      for (int i = 0; i < n; i++) send_beat(base + DW'(i), (i == n - 1), rnd);
      wait_start("frame_start_seen");
      chk("frame_size", CDW'(core_size), CDW'(n));
      chk("frame_data", core_data, exp_data(n, base));
      repeat (dly) tick();
      core_hash = h;
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      receive(h, n, 2'b00, rnd);
   endtask

   initial begin
      int s0;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      core_hash = '0; core_done = 1'b0; out_ready = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_in_ready", CDW'(in_ready), CDW'(0));
      chk("rst_start", CDW'(core_start), CDW'(0));
      chk("rst_out_valid", CDW'(out_valid), CDW'(0));
      chk("rst_busy", CDW'(busy), CDW'(0));
      chk("rst_data", core_data, CDW'(0));
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready_low", CDW'(in_ready), CDW'(0));
      tick();
      chk("rel_in_ready_high", CDW'(in_ready), CDW'(1));

      // 3-element frame, core answers 10 cycles after start
      send_beat(32'h1, 1'b0, 1'b0);
      send_beat(32'h2, 1'b0, 1'b0);
      send_beat(32'h3, 1'b1, 1'b0);
      chk("f1_start", CDW'(core_start), CDW'(1));
      chk("f1_size", CDW'(core_size), CDW'(3));
      chk("f1_data", core_data, exp_data(3, 32'h1));
      chk("f1_busy", CDW'(busy), CDW'(1));
      chk("f1_in_ready", CDW'(in_ready), CDW'(0));
      tick();
      chk("f1_start_one_cycle", CDW'(core_start), CDW'(0));
      repeat (8) tick();
      chk("f1_valid_before_done", CDW'(out_valid), CDW'(0));
      core_hash = 32'hABCD;
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      chk("f1_valid_after_done", CDW'(out_valid), CDW'(1));
      chk("f1_hash", CDW'(out_hash), CDW'(32'hABCD));
      receive(32'hABCD, 3, 2'b00, 1'b0);

      // Overflow: 16 beats, last on the 16th, no core start
      s0 = n_starts;
      for (int i = 0; i < 16; i++) send_beat(32'h10 + 32'(i), (i == 15), 1'b0);
      chk("ovf_no_start_now", CDW'(core_start), CDW'(0));
      chk("ovf_valid", CDW'(out_valid), CDW'(1));
      chk("ovf_data_kept", core_data, exp_data(15, 32'h10));
      receive(32'h0, 15, 2'b01, 1'b0);
      chk("ovf_no_start_total", CDW'(n_starts), CDW'(s0));

      // Timeout: core never answers
      send_beat(32'h21, 1'b0, 1'b0);
      send_beat(32'h22, 1'b1, 1'b0);
      chk("to_start", CDW'(core_start), CDW'(1));
      repeat (16) tick();
      chk("to_valid_at_16", CDW'(out_valid), CDW'(0));
      tick();
      chk("to_valid_at_17", CDW'(out_valid), CDW'(1));
      chk("to_err", CDW'(out_err), CDW'(2'b10));
      chk("to_hash", CDW'(out_hash), CDW'(0));
      core_hash = 32'h5555;
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      chk("late_done_hash", CDW'(out_hash), CDW'(0));
      chk("late_done_err", CDW'(out_err), CDW'(2'b10));
      // Hold the result for 20 cycles
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("hold_valid", CDW'(out_valid), CDW'(1));
         chk("hold_in_ready", CDW'(in_ready), CDW'(0));
         chk("hold_err", CDW'(out_err), CDW'(2'b10));
         chk("hold_count", CDW'(out_count), CDW'(2));
      end
      receive(32'h0, 2, 2'b00 | 2'b10, 1'b0);
      core_hash = 32'h7777;
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      tick();
      chk("late_done_idle_valid", CDW'(out_valid), CDW'(0));
      chk("late_done_idle_busy", CDW'(busy), CDW'(0));

      // Back-to-back frames with random gaps and backpressure
      run_frame(1, 32'h100, 32'h1111, $urandom_range(1, 5), 1'b1);
      run_frame(15, 32'h200, 32'h2222, $urandom_range(1, 5), 1'b1);

      // Reset during WAIT, stray done afterwards
      send_beat(32'h31, 1'b1, 1'b0);
      chk("rw_start", CDW'(core_start), CDW'(1));
      repeat (3) tick();
      chk("rw_busy", CDW'(busy), CDW'(1));
      rst_n = 1'b0;
      #1;
      chk("rw_start_low", CDW'(core_start), CDW'(0));
      chk("rw_valid_low", CDW'(out_valid), CDW'(0));
      chk("rw_busy_low", CDW'(busy), CDW'(0));
      chk("rw_in_ready_low", CDW'(in_ready), CDW'(0));
      chk("rw_size_low", CDW'(core_size), CDW'(0));
      chk("rw_data_low", core_data, CDW'(0));
      chk("rw_hash_low", CDW'(out_hash), CDW'(0));
      chk("rw_err_low", CDW'(out_err), CDW'(0));
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();
      core_hash = 32'hDEAD;
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      chk("rw_stray_valid", CDW'(out_valid), CDW'(0));
      chk("rw_stray_hash", CDW'(out_hash), CDW'(0));
      tick();
      chk("rw_stray_busy", CDW'(busy), CDW'(0));
      chk("rw_ready_again", CDW'(in_ready), CDW'(1));
      run_frame(2, 32'h300, 32'h3333, 3, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/poseidon2_stream_adapter.md
Name: poseidon2_stream_adapter

Overview:
- Streaming front-end for the Poseidon2 hash core; generalises the fixed 15-input parallel port to a parametrised element count.
- Collects field elements beat-by-beat over valid/ready, packs them into a flat operand vector with an element count, and pulses start to the core.
- Waits for done with a timeout, then returns the digest over a valid/ready result channel with error flags.

Parameters:
- DATA_W, 256, width of one field element and of the digest
- MAX_ELEMS, 15, maximum elements per frame
- SIZE_W, 4, width of size/count fields; must satisfy 2**SIZE_W > MAX_ELEMS
- TIMEOUT_CYC, 4096, cycles allowed in WAIT before abort; must be >= 1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input element valid
- in_ready  out  1  adapter accepts element
- in_data  in  DATA_W  field element
- in_last  in  1  final element of frame
- core_start  out  1  one-cycle start pulse to hash core
- core_size  out  SIZE_W  element count of issued frame
- core_data  out  MAX_ELEMS*DATA_W  packed elements; slot i at bits [i*DATA_W +: DATA_W]
- core_hash  in  DATA_W  digest from core
- core_done  in  1  digest valid pulse from core
- out_valid  out  1  result valid
- out_ready  in  1  result consumer ready
- out_hash  out  DATA_W  digest (0 on error)
- out_count  out  SIZE_W  elements in frame
- out_err  out  2  bit0 overflow, bit1 timeout
- busy  out  1  high in ISSUE, WAIT, RESULT

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. Reset forces state COLLECT, count 0, all slots 0, timeout counter 0, overflow flag 0. All outputs are 0 while rst_n is low.
- in_ready is registered. It rises on the first clk edge after rst_n deasserts.
- Handshake: a transfer occurs on a rising edge with valid && ready on that channel. in_ready = 1 only in COLLECT.
- COLLECT:
  - Accepted beat with count < MAX_ELEMS: write in_data to slot[count]; count++.
  - Accepted beat with count == MAX_ELEMS: discard data; set sticky overflow.
  - Accepted beat with in_last: go to ISSUE if overflow is clear, else go to RESULT with out_hash = 0 and out_err = 2'b01. No core_start is issued on overflow.
- ISSUE: core_start = 1 for exactly one cycle; core_size = count. Next state is WAIT.
- core_data and core_size are stable from ISSUE until leaving WAIT. Unused slots read 0.
- WAIT:
  - core_done = 1: latch core_hash into out_hash; go to RESULT with err 0.
  - Timeout counter increments each WAIT cycle. If it reaches TIMEOUT_CYC without done: out_hash = 0, out_err = 2'b10, go to RESULT.
  - If done and timeout coincide, done wins.
- core_done is ignored outside WAIT.
- RESULT: out_valid = 1; out_hash, out_count and out_err are held until out_ready. On the transfer: clear slots, count, overflow and timeout counter; out_valid = 0; return to COLLECT, with in_ready = 1 the next cycle.
- Latency:
  - Last beat accepted at edge T: core_start high in cycle T+1.
  - core_done sampled at edge D: out_valid high from D+1.
  - Minimum frame turnaround is 1 idle cycle on in_ready after result handoff.
- Single-element frame is legal (size 1). Empty frames cannot occur.
- Reset mid-operation:
  - Any state aborts immediately. core_start and out_valid drop asynchronously.
  - A core_done arriving after reset is ignored.

Test Plan:
- 3-element frame 0x1, 0x2, 0x3 with last on 3rd; core model returns 0xABCD 10 cycles after start -> core_start pulse 1 cycle, core_size = 3, slots 3..14 = 0; out_valid one cycle after done; out_hash = 0xABCD, out_count = 3, out_err = 0.
- 15-element frame followed by a 16th element with last -> no core_start; out_err = 2'b01, out_hash = 0, out_count = 15.
- Core never asserts done, TIMEOUT_CYC = 16 -> out_valid after 16 WAIT cycles; out_err = 2'b10, out_hash = 0. A late core_done is ignored.
- Hold out_ready = 0 for 20 cycles in RESULT -> outputs stable, in_ready = 0. Release -> one transfer, then in_ready = 1 next cycle.
- Back-to-back frames of sizes 1 and 15 with random in_valid gaps and random out_ready backpressure -> digests match the core model in order; no beat lost or duplicated.
- Assert rst_n low during WAIT, then core_done 2 cycles after release -> all outputs 0, no result produced, next frame processed normally.
